// File: rtl/rr_mux_reg.sv
// NCH-input, WIDTH-bit mux with per-channel valid/ready, explicit-select or round-robin steering
// and a single registered output stage. Define RR_MUX_PERF_EN to add the output-transfer counter.
module rr_mux_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NCH*WIDTH-1:0] Din,
    input  logic [NCH-1:0]       Valid_in,
    output logic [NCH-1:0]       Ready_in,
    input  logic                 Mode,
    input  logic [SELW-1:0]      Sel,
    output logic [WIDTH-1:0]     Dout,
    output logic                 Valid_out,
    input  logic                 Ready_out,
`ifdef RR_MUX_PERF_EN
    input  logic                 Count_clr,
    output logic [15:0]          Xfer_count,
`endif
    output logic [SELW-1:0]      Grant
);

    logic [WIDTH-1:0] dout_q;
    logic [SELW-1:0]  grant_q;
    logic             valid_q;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             load;
    logic             cand_ok;
    logic [SELW-1:0]  cand;
    logic             xfer;
    logic [WIDTH-1:0] cand_data;
    int unsigned      idx;

    assign load = !valid_q || Ready_out;

    // Candidate selection: explicit Sel (if in range) or first valid channel from rr_ptr.
    always_comb begin
        cand_ok = 1'b0;
        cand    = '0;
        idx     = 0;
        if (!Mode) begin
            if (32'(Sel) < NCH) begin
                cand_ok = 1'b1;
                cand    = Sel;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                idx = 32'(rr_ptr_q) + i;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                if (!cand_ok && Valid_in[idx]) begin
                    cand_ok = 1'b1;
                    cand    = SELW'(idx);
                end
            end
        end
    end

    // Reset gates Ready_in so nothing is accepted while the register is being cleared.
    always_comb begin
        Ready_in  = '0;
        xfer      = 1'b0;
        cand_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(cand) == i) begin
                Ready_in[i] = cand_ok && load && !Reset;
                cand_data   = Din[i*WIDTH +: WIDTH];
            end
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            xfer = xfer | (Ready_in[i] & Valid_in[i]);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (Mode && xfer) begin
            rr_ptr_d = (32'(cand) == NCH - 1) ? '0 : cand + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            dout_q   <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            if (xfer) begin
                dout_q  <= cand_data;
                grant_q <= cand;
                valid_q <= 1'b1;
            end else if (Ready_out) begin
                valid_q <= 1'b0;
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign Dout      = dout_q;
    assign Grant     = grant_q;
    assign Valid_out = valid_q;

`ifdef RR_MUX_PERF_EN
    logic [15:0] xfer_count_q;

    always_ff @(posedge Clk) begin
        if (Reset || Count_clr) begin
            xfer_count_q <= '0;
        end else if (valid_q && Ready_out && xfer_count_q != 16'hFFFF) begin
            xfer_count_q <= xfer_count_q + 16'd1;
        end
    end

    assign Xfer_count = xfer_count_q;
`endif

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised successor to the combinational 2:1 datapath mux.
- NCH-input, WIDTH-bit mux with per-channel valid/ready handshake, a selectable steering mode (explicit select or round-robin) and one registered output stage.
- Used where several MIPS datapath producers share one consumer port, e.g. writeback sources or stall-capable forwarding paths.

Parameters:
- WIDTH, 32, data width per channel.
- NCH, 4, number of input channels; legal range 2..16, need not be a power of two.
- SELW, 2, select/grant width; must satisfy 2^SELW >= NCH.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Din  input  NCH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- Valid_in  input  NCH  per-channel data valid.
- Ready_in  output  NCH  per-channel accept; combinational, at most one bit set.
- Mode  input  1  0 = explicit select via Sel; 1 = round-robin.
- Sel  input  SELW  channel index, used only when Mode = 0.
- Dout  output  WIDTH  registered output data.
- Valid_out  output  1  output register holds valid data.
- Ready_out  input  1  downstream accepts Dout this cycle.
- Grant  output  SELW  index of the channel whose data is in Dout.

Behaviour:
- Reset, on the Clk edge with Reset = 1: Dout = 0, Valid_out = 0, Grant = 0, round-robin pointer rr_ptr = 0. Reset has priority over every other event.
- Reset mid-transfer discards any held output with no handshake.
- Load condition: load = !Valid_out || Ready_out. The output register can accept whenever it is empty or being drained in the same cycle (full throughput).
- Mode 0 arbitration:
  - candidate = Sel.
  - If Sel >= NCH, no channel is eligible and Ready_in = 0.
  - Otherwise Ready_in[Sel] = load; all other bits are 0.
- Mode 1 arbitration:
  - Search channels rr_ptr, rr_ptr+1, … modulo NCH.
  - The first channel with Valid_in set wins.
  - Ready_in[win] = load; all other bits are 0.
- Transfer from channel c occurs when Valid_in[c] && Ready_in[c]. On the next edge: Dout = Din[c], Grant = c, Valid_out = 1.
- Pointer update: in Mode 1 only, a transfer sets rr_ptr = (c+1) mod NCH. Wrap uses compare-and-reset, not a power-of-two mask. rr_ptr is unchanged in Mode 0 and on cycles with no transfer.
- No transfer and Ready_out = 1: Valid_out goes to 0; Dout and Grant hold their last value.
- Valid_out = 1 and Ready_out = 0: Dout, Grant and Valid_out hold, and all Ready_in bits are 0.
- Latency: one cycle from input transfer to Valid_out. Sustained throughput: one word per cycle.
- Mode or Sel changes take effect in the same-cycle arbitration and never alter data already held.
- Input valid may drop without a handshake; the block makes no commitment until Ready_in is asserted.
- No X propagation: unused Grant codes never appear on Grant.

Optional Feature:
- Macro: RR_MUX_PERF_EN.
- When defined:
  - Adds output Xfer_count, 16 bits, reset to 0.
  - Increments by 1 on every output transfer (Valid_out && Ready_out).
  - Saturates at 16'hFFFF.
  - Adds input Count_clr, 1 bit, which synchronously clears the counter. Count_clr has priority over an increment in the same cycle.
- When undefined: neither port exists and the logic is absent.

Test Plan:
- Reset with Mode = 0, Sel = 0, all Valid_in = 1 → after reset, Dout = 0, Valid_out = 0, Grant = 0, Ready_in = 4'b0000 only while Reset is high; first accept one cycle after Reset is deasserted.
- Mode 0, Sel = 1, Din ch0 = 0, ch1 = 1, Valid_in = 4'b0011, Ready_out = 1 → Ready_in = 4'b0010; next cycle Dout = 1, Grant = 1, Valid_out = 1. Switching Sel to 0 gives Dout = 0 one cycle later.
- Mode 1, Valid_in = 4'b1111, Din ch i = 32'hA0+i, Ready_out held 1 → Dout sequence A0, A1, A2, A3, A0 on consecutive cycles; Grant sequence 0, 1, 2, 3, 0.
- Backpressure: Mode 1, output valid with Dout = 32'hA2, Ready_out = 0 for 3 cycles → Dout/Grant/Valid_out stable, Ready_in = 0. On Ready_out = 1, the next data (A3) loads that same edge.
- Boundary: Mode 0 with Sel = 3 and NCH = 3 → no Ready_in bit is set and Valid_out drains to 0. Mode 1 with NCH = 3, Valid_in = 3'b101 → grants 0, 2, 0, 2 (wrap from 2 to 0).
- RR_MUX_PERF_EN: 5 transfers → Xfer_count = 5. Count_clr asserted coincident with a transfer → Xfer_count = 0. Preload to 16'hFFFE, then 3 transfers → count saturates at 16'hFFFF.
